// File: rtl/ste_dma_if.sv
// ste_dma_if
// Bundles the MCU-side register/burst bus and the byte-wide device port of
// the STE floppy/hard-disk DMA channel.
//   FCS_N        register select from MCU, active low
//   RW           1 = read, 0 = write
//   A1           0 = data/sector-count register, 1 = mode/status register
//   DIN[15:0]    CPU write data / memory burst data
//   DOUT[15:0]   register read data or FIFO head word
//   RDY_I        MCU word-transfer strobe, active low
//   RDY_O        burst request to MCU, active low
//   dev_drq      device byte request
//   dev_rd_data  byte from device
//   dev_wr_data  byte to device
//   dev_ack      byte-transfer acknowledge
// The DMA channel connects through the slave modport; the MCU/device side
// (or a testbench) connects through the master modport.
interface ste_dma_if;
  logic        FCS_N;
  logic        RW;
  logic        A1;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic        RDY_I;
  logic        RDY_O;
  logic        dev_drq;
  logic [7:0]  dev_rd_data;
  logic [7:0]  dev_wr_data;
  logic        dev_ack;

  modport master (
    output FCS_N, RW, A1, DIN, RDY_I, dev_drq, dev_rd_data,
    input  DOUT, RDY_O, dev_wr_data, dev_ack
  );

  modport slave (
    input  FCS_N, RW, A1, DIN, RDY_I, dev_drq, dev_rd_data,
    output DOUT, RDY_O, dev_wr_data, dev_ack
  );
endinterface

// File: rtl/ste_dma.sv
// ste_dma
// Floppy/hard-disk DMA channel. Moves bytes between the device port and the
// word-wide memory bus through a 16-word FIFO, requesting 8-word bursts from
// the MCU over the active-low RDY handshake.
//   clk32   system clock
//   resb    asynchronous active-low reset
//   clk_en  8 MHz enable; all state advances only when high
//   bus     ste_dma_if.slave: register window, burst handshake, device port
module ste_dma (
  input  logic        clk32,
  input  logic        resb,
  input  logic        clk_en,
  ste_dma_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} burst_state_t;

  // Programmable state
  logic        dir;
  logic        scsel;
  logic [7:0]  cnt;
  logic        err;

  // FIFO storage and bookkeeping
  logic [15:0] fifo_mem [16];
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;
  logic [4:0]  fifo_cnt;
  logic        byte_phase;
  logic [7:0]  hi_byte;

  // Burst engine
  burst_state_t state;
  logic [2:0]  word_cnt;
  logic [4:0]  burst_cnt;

  // Registered outputs
  logic        rdy_o;
  logic        dev_ack;
  logic [7:0]  dev_wr_data;

  logic        reg_wr, mode_wr, dma_reset, cnt_wr;
  logic        bus_xfer, burst_end, start_burst;
  logic        dev_go, rd_accept, wr_accept;
  logic        push, pop;
  logic        fifo_full, fifo_empty;
  logic [15:0] push_word, head_word, status_word, reg_rdata;

  assign fifo_full  = (fifo_cnt == 5'd16);
  assign fifo_empty = (fifo_cnt == 5'd0);

  assign reg_wr    = !bus.FCS_N && !bus.RW;
  assign mode_wr   = reg_wr && bus.A1;
  // Flipping the direction bit is the only way software restarts the channel.
  assign dma_reset = mode_wr && (bus.DIN[8] != dir);
  assign cnt_wr    = reg_wr && !bus.A1 && scsel;

  assign bus_xfer  = (state == REQ) && !bus.RDY_I;
  assign burst_end = bus_xfer && (word_cnt == 3'd7);

  // dev_ack blocks a new byte so each byte gets a full ack period.
  assign dev_go    = bus.dev_drq && !dev_ack;
  assign rd_accept = !dir && dev_go && (cnt != 8'd0) && !fifo_full;
  assign wr_accept = dir && dev_go && !fifo_empty;

  // Device bytes only reach the FIFO once the low half completes the word.
  assign push = (rd_accept && byte_phase) || (dir && bus_xfer);
  assign pop  = (wr_accept && byte_phase) || (!dir && bus_xfer);

  assign push_word = dir ? bus.DIN : {hi_byte, bus.dev_rd_data};
  assign head_word = fifo_mem[rd_ptr];

  // Read bursts need a full burst waiting; write bursts need room for one and
  // sectors still outstanding.
  assign start_burst = (state == IDLE) &&
                       (dir ? ((fifo_cnt <= 5'd8) && (cnt != 8'd0))
                            : (fifo_cnt >= 5'd8));

  assign status_word = {13'b0, bus.dev_drq, (cnt != 8'd0), ~err};
  assign reg_rdata   = bus.A1 ? status_word : 16'h0000;

  always_comb begin
    bus.DOUT = 16'h0000;
    if (!bus.FCS_N && bus.RW)
      bus.DOUT = reg_rdata;
    else if (!bus.RDY_I && !dir)
      bus.DOUT = head_word;
  end

  assign bus.RDY_O       = rdy_o;
  assign bus.dev_ack     = dev_ack;
  assign bus.dev_wr_data = dev_wr_data;

  // FIFO storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk32) begin
    if (clk_en && push && !dma_reset)
      fifo_mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      dir         <= 1'b0;
      scsel       <= 1'b0;
      cnt         <= 8'd0;
      err         <= 1'b0;
      wr_ptr      <= 4'd0;
      rd_ptr      <= 4'd0;
      fifo_cnt    <= 5'd0;
      byte_phase  <= 1'b0;
      hi_byte     <= 8'd0;
      state       <= IDLE;
      word_cnt    <= 3'd0;
      burst_cnt   <= 5'd0;
      rdy_o       <= 1'b1;
      dev_ack     <= 1'b0;
      dev_wr_data <= 8'd0;
    end else if (clk_en) begin
      if (mode_wr) begin
        dir   <= bus.DIN[8];
        scsel <= bus.DIN[4];
      end

      if (dma_reset) begin
        wr_ptr     <= 4'd0;
        rd_ptr     <= 4'd0;
        fifo_cnt   <= 5'd0;
        byte_phase <= 1'b0;
        err        <= 1'b0;
        state      <= IDLE;
        word_cnt   <= 3'd0;
        rdy_o      <= 1'b1;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 4'd1;
        if (pop)
          rd_ptr <= rd_ptr + 4'd1;
        fifo_cnt <= fifo_cnt + 5'(push) - 5'(pop);

        if (rd_accept || wr_accept)
          byte_phase <= ~byte_phase;
        if (rd_accept && !byte_phase)
          hi_byte <= bus.dev_rd_data;
        if (wr_accept)
          dev_wr_data <= byte_phase ? head_word[7:0] : head_word[15:8];

        // A request with no sectors left is a software error, sticky until
        // the channel is restarted.
        if (!dir && bus.dev_drq && (cnt == 8'd0))
          err <= 1'b1;

        case (state)
          IDLE: begin
            if (start_burst) begin
              state    <= REQ;
              rdy_o    <= 1'b0;
              word_cnt <= 3'd0;
            end
          end
          REQ: begin
            if (bus_xfer) begin
              word_cnt <= word_cnt + 3'd1;
              if (word_cnt == 3'd7) begin
                state <= GAP;
                rdy_o <= 1'b1;
              end
            end
          end
          GAP: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            rdy_o <= 1'b1;
          end
        endcase
      end

      dev_ack <= (rd_accept || wr_accept) && !dma_reset;

      // 32 bursts of 8 words make one 512-byte sector.
      if (cnt_wr) begin
        cnt       <= bus.DIN[7:0];
        burst_cnt <= 5'd0;
      end else if (burst_end && !dma_reset) begin
        burst_cnt <= burst_cnt + 5'd1;
        if ((burst_cnt == 5'd31) && (cnt != 8'd0))
          cnt <= cnt - 8'd1;
      end
    end
  end

endmodule
